// File: rtl/spi_shift_baud_core.sv
// SPI master shift engine: baud divider, SCLK/MOSI generation, MISO capture and
// slave-select framing for one DATA_WIDTH-bit transfer per send_data strobe.
module spi_shift_baud_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  mstr,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsbfe,
    input  logic                  spiswai,
    input  logic [1:0]            spi_mode,
    input  logic [2:0]            sppr,
    input  logic [2:0]            spr,
    input  logic                  send_data,
    input  logic [DATA_WIDTH-1:0] mosi_data,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  ss,
    output logic                  tip,
    output logic                  receive_data,
    output logic [DATA_WIDTH-1:0] miso_data
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int EW = $clog2(2*DATA_WIDTH) + 1;
    localparam logic [EW-1:0] LAST_E = EW'(2*DATA_WIDTH-1);
    localparam logic [EW-1:0] DONE_E = EW'(2*DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t                r_state;
    logic [10:0]           r_cnt;
    logic [EW-1:0]         r_edge;
    logic [IW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic                  r_cpol, r_cpha, r_lsbfe;
    logic [2:0]            r_sppr, r_spr;

    logic          w_run_ok, w_freeze, w_abort, w_tick, w_sample, w_shift, w_first;
    logic [10:0]   w_hm1_live, w_hm1;
    logic [IW-1:0] w_nbit, w_idx, w_nidx;

    assign w_run_ok   = mstr & ((spi_mode == 2'b00) | ((spi_mode == 2'b01) & ~spiswai));
    assign w_freeze   = mstr & (spi_mode == 2'b01) & spiswai;
    assign w_abort    = ~mstr | spi_mode[1];
    // Half-period minus one; 11 bits covers the 1024-cycle maximum.
    assign w_hm1_live = ((11'(sppr) + 11'd1) << spr) - 11'd1;
    assign w_hm1      = ((11'(r_sppr) + 11'd1) << r_spr) - 11'd1;
    assign w_tick     = (r_cnt == 11'd0);
    assign w_nbit     = r_bit + IW'(1);
    assign w_idx      = r_lsbfe ? r_bit  : IW'(DATA_WIDTH-1) - r_bit;
    assign w_nidx     = r_lsbfe ? w_nbit : IW'(DATA_WIDTH-1) - w_nbit;
    assign w_first    = lsbfe ? mosi_data[0] : mosi_data[DATA_WIDTH-1];
    // Sampling edge parity follows cpha; shifting happens on the other parity.
    assign w_sample   = r_cpha ? r_edge[0] : ~r_edge[0];
    assign w_shift    = r_cpha ? (~r_edge[0] & (r_edge != '0))
                               : (r_edge[0] & (r_edge != LAST_E));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_edge       <= '0;
            r_bit        <= '0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_cpol       <= 1'b0;
            r_cpha       <= 1'b0;
            r_lsbfe      <= 1'b0;
            r_sppr       <= '0;
            r_spr        <= '0;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
            ss           <= 1'b1;
            tip          <= 1'b0;
            receive_data <= 1'b0;
            miso_data    <= '0;
        end else begin
            receive_data <= 1'b0;
            case (r_state)
                IDLE: begin
                    ss   <= 1'b1;
                    tip  <= 1'b0;
                    sclk <= cpol;
                    // A strobe coinciding with the completion pulse is dropped.
                    if (send_data & w_run_ok & ~receive_data) begin
                        r_tx    <= mosi_data;
                        r_cpol  <= cpol;
                        r_cpha  <= cpha;
                        r_lsbfe <= lsbfe;
                        r_sppr  <= sppr;
                        r_spr   <= spr;
                        r_cnt   <= w_hm1_live;
                        r_edge  <= '0;
                        r_bit   <= '0;
                        mosi    <= w_first;
                        ss      <= 1'b0;
                        tip     <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                default: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        ss      <= 1'b1;
                        tip     <= 1'b0;
                        sclk    <= cpol;
                    end else if (!w_freeze) begin
                        r_cnt <= w_tick ? w_hm1 : r_cnt - 11'd1;
                        if (w_tick) begin
                            if (r_state == HOLD) begin
                                ss           <= 1'b1;
                                tip          <= 1'b0;
                                sclk         <= r_cpol;
                                miso_data    <= r_rx;
                                receive_data <= 1'b1;
                                r_state      <= IDLE;
                            end else if (r_edge == DONE_E) begin
                                r_state <= HOLD;
                            end else begin
                                // The tick ending SETUP is SCLK edge 0.
                                sclk <= ~sclk;
                                if (w_sample) r_rx[w_idx] <= miso;
                                if (w_shift) begin
                                    r_bit <= w_nbit;
                                    mosi  <= r_tx[w_nidx];
                                end
                                r_edge  <= r_edge + EW'(1);
                                r_state <= XFER;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_shift_baud_core.sv
// Directed bench for spi_shift_baud_core: a negedge slave model drives MISO,
// captures MOSI and measures SCLK/SS timing; steps check against fixed values.
module tb_spi_shift_baud_core;
    logic       PCLK = 1'b0;
    logic       PRESETn, mstr, cpol, cpha, lsbfe, spiswai;
    logic [1:0] spi_mode;
    logic [2:0] sppr, spr;
    logic       send_data;
    logic [7:0] mosi_data;
    logic       miso;
    logic       sclk, mosi, ss, tip, receive_data;
    logic [7:0] miso_data;

    spi_shift_baud_core #(.DATA_WIDTH(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .mstr(mstr), .cpol(cpol), .cpha(cpha),
        .lsbfe(lsbfe), .spiswai(spiswai), .spi_mode(spi_mode), .sppr(sppr),
        .spr(spr), .send_data(send_data), .mosi_data(mosi_data), .miso(miso),
        .sclk(sclk), .mosi(mosi), .ss(ss), .tip(tip),
        .receive_data(receive_data), .miso_data(miso_data)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc++;

    int         tests = 0, fails = 0;
    int         tog = 0, low = 0, rxp = 0, first_cyc = 0, ssfall_cyc = 0, last_cyc = 0, half = 0;
    logic [7:0] cap_msb = 8'h00, cap_lsb = 8'h00, slave_byte = 8'h00;
    logic       ss_prev = 1'b1, sclk_prev = 1'b0;

    // Slave model: bit k is presented until the sampling edge k has occurred.
    always @(negedge PCLK) begin
        int e, k;
        if (ss_prev && !ss) begin
            tog = 0; low = 0; ssfall_cyc = cyc; last_cyc = cyc;
            cap_msb = 8'h00; cap_lsb = 8'h00;
        end
        if (!ss) low++;
        if (!ss && sclk !== sclk_prev) begin
            tog++;
            e = tog - 1;
            if (tog == 1) first_cyc = cyc;
            half = cyc - last_cyc;
            last_cyc = cyc;
            if (cpha ? e[0] : !e[0]) begin
                cap_msb = {cap_msb[6:0], mosi};
                cap_lsb = {mosi, cap_lsb[7:1]};
            end
        end
        if (receive_data) rxp++;
        k = tog >> 1;
        if (k < 8) miso = lsbfe ? slave_byte[k] : slave_byte[7-k];
        ss_prev   = ss;
        sclk_prev = sclk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin @(posedge PCLK); #1; end
    endtask

    task automatic send(input logic [7:0] d);
        @(posedge PCLK); #1;
        mosi_data = d; send_data = 1'b1;
        @(posedge PCLK); #1;
        send_data = 1'b0;
        @(negedge PCLK); #1;
    endtask

    task automatic wait_tog(input int n, input int budget);
        int b = 0;
        while (tog < n && b < budget) begin @(posedge PCLK); #1; b++; end
        if (tog < n) chk("tog_timeout", tog, n);
    endtask

    task automatic wait_idle(input int budget);
        int b = 0;
        while (ss !== 1'b1 && b < budget) begin @(posedge PCLK); #1; b++; end
        if (ss !== 1'b1) chk("idle_timeout", ss, 1);
        @(negedge PCLK); #1;
    endtask

    initial begin
        int   r0;
        logic s0;
        PRESETn = 1'b0; mstr = 1'b1; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
        spiswai = 1'b0; spi_mode = 2'b00; sppr = 3'd0; spr = 3'd0;
        send_data = 1'b0; mosi_data = 8'h00;
        #12;
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_ss", ss, 1);
        chk("rst_tip", tip, 0);
        chk("rst_rxd", receive_data, 0);
        chk("rst_miso_data", miso_data, 8'h00);
        @(negedge PCLK); PRESETn = 1'b1;
        tick_n(2);

        // Mode 0, MSB first, H=1
        slave_byte = 8'h3C; r0 = rxp;
        send(8'hA5);
        wait_idle(100);
        chk("t1_toggles", tog, 16);
        chk("t1_first_edge", first_cyc - ssfall_cyc, 1);
        chk("t1_half", half, 1);
        chk("t1_ss_low", low, 18);
        chk("t1_mosi", cap_msb, 8'hA5);
        chk("t1_rx_pulses", rxp - r0, 1);
        chk("t1_miso_data", miso_data, 8'h3C);
        chk("t1_tip", tip, 0);

        // Mode 3, LSB first, H=7
        cpol = 1'b1; cpha = 1'b1; lsbfe = 1'b1; sppr = 3'd6;
        tick_n(2);
        chk("t2_idle_sclk", sclk, 1);
        slave_byte = 8'hAA;
        send(8'h80);
        wait_idle(400);
        chk("t2_toggles", tog, 16);
        chk("t2_half", half, 7);
        chk("t2_ss_low", low, 126);
        chk("t2_mosi", cap_lsb, 8'h80);
        chk("t2_miso_data", miso_data, 8'hAA);
        chk("t2_end_sclk", sclk, 1);

        // Maximum divider, then abort to cut the run short
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; sppr = 3'd7; spr = 3'd7;
        send(8'h00);
        wait_tog(3, 4000);
        chk("t3_half", half, 1024);
        chk("t3_first_edge", first_cyc - ssfall_cyc, 1024);
        spi_mode = 2'b10;
        tick_n(1);
        chk("t3_abort_ss", ss, 1);
        spi_mode = 2'b00; sppr = 3'd1; spr = 3'd0;
        tick_n(2);

        // Wait-mode freeze for 50 cycles after the 5th edge, H=2
        spiswai = 1'b1; slave_byte = 8'hC3;
        send(8'h3C);
        wait_tog(5, 100);
        s0 = sclk;
        spi_mode = 2'b01;
        tick_n(50);
        chk("t4_frozen_tog", tog, 5);
        chk("t4_frozen_sclk", sclk, s0);
        chk("t4_frozen_ss", ss, 0);
        spi_mode = 2'b00;
        wait_idle(200);
        chk("t4_ss_low", low, 86);
        chk("t4_toggles", tog, 16);
        chk("t4_mosi", cap_msb, 8'h3C);
        chk("t4_miso_data", miso_data, 8'hC3);

        // Abort mid-transfer, then a clean transfer
        spiswai = 1'b0; sppr = 3'd0; slave_byte = 8'h00; r0 = rxp;
        send(8'h11);
        wait_tog(4, 50);
        spi_mode = 2'b10;
        tick_n(1);
        chk("t5_abort_ss", ss, 1);
        chk("t5_abort_tip", tip, 0);
        chk("t5_abort_sclk", sclk, 0);
        tick_n(5);
        chk("t5_no_pulse", rxp - r0, 0);
        chk("t5_keep_data", miso_data, 8'hC3);
        spi_mode = 2'b00; slave_byte = 8'h5E;
        send(8'h77);
        wait_idle(100);
        chk("t5_miso_data", miso_data, 8'h5E);
        chk("t5_pulse", rxp - r0, 1);
        chk("t5_mosi", cap_msb, 8'h77);

        // Strobe while busy is ignored; then reset mid-transfer
        slave_byte = 8'h81;
        send(8'h5A);
        wait_tog(4, 50);
        send(8'hFF);
        wait_idle(100);
        chk("t6_mosi", cap_msb, 8'h5A);
        chk("t6_toggles", tog, 16);
        chk("t6_miso_data", miso_data, 8'h81);
        send(8'h33);
        wait_tog(3, 50);
        PRESETn = 1'b0;
        #1;
        chk("t6_rst_ss", ss, 1);
        chk("t6_rst_sclk", sclk, 0);
        chk("t6_rst_tip", tip, 0);
        chk("t6_rst_miso_data", miso_data, 8'h00);
        #20;
        PRESETn = 1'b1;
        tick_n(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
